// File: rtl/stream_semaphore_arbiter_if.sv
// Stream bundle between NUM_REQ requesters, the arbiter and the shared pipeline.
// master = arbiter view, slave = requester/pipeline view.
interface stream_semaphore_arbiter_if #(
  parameter int NUM_REQ      = 2,
  parameter int STREAM_WIDTH = 32,
  parameter int KEEP_WIDTH   = 1
);
  logic [NUM_REQ-1:0]              s_axis_tvalid;
  logic [NUM_REQ-1:0]              s_axis_tready;
  logic [NUM_REQ-1:0]              s_axis_tlast;
  logic [NUM_REQ*STREAM_WIDTH-1:0] s_axis_tdata;
  logic [NUM_REQ*KEEP_WIDTH-1:0]   s_axis_tkeep;
  logic [NUM_REQ-1:0]              s_fence;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic                            m_axis_tlast;
  logic [STREAM_WIDTH-1:0]         m_axis_tdata;
  logic [KEEP_WIDTH-1:0]           m_axis_tkeep;

  modport master (
    input  s_axis_tvalid,
    output s_axis_tready,
    input  s_axis_tlast,
    input  s_axis_tdata,
    input  s_axis_tkeep,
    input  s_fence,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast,
    output m_axis_tdata,
    output m_axis_tkeep
  );

  modport slave (
    output s_axis_tvalid,
    input  s_axis_tready,
    output s_axis_tlast,
    output s_axis_tdata,
    output s_axis_tkeep,
    output s_fence,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast,
    input  m_axis_tdata,
    input  m_axis_tkeep
  );
endinterface

// File: rtl/stream_semaphore_arbiter.sv
// Packet round-robin arbiter feeding one pipeline, with in-flight credit
// counting and optional drain-before-start fence per packet.
module stream_semaphore_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int STREAM_WIDTH  = 32,
  parameter int KEEP_WIDTH    = 1,
  parameter int MAX_IN_FLIGHT = 128,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  aclk,
  input  logic                  reset,
  stream_semaphore_arbiter_if.master bus,
  input  logic                  sigRelease,
  output logic                  released,
  output logic [NUM_REQ-1:0]    grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    STREAM
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PTR_W-1:0]     r_rr;
  logic [PTR_W-1:0]     w_rr_nxt;
  logic [PTR_W-1:0]     r_gidx;
  logic [PTR_W-1:0]     w_gidx_nxt;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   w_grant_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_released;

  logic                 w_found;
  logic [PTR_W-1:0]     w_win;
  logic [PTR_W-1:0]     w_idx;
  logic [SUM_W-1:0]     w_sum;

  logic                    w_ok;
  logic                    w_stream;
  logic                    w_vsel;
  logic                    w_mvalid;
  logic                    w_fwd;
  logic                    w_last;
  logic                    w_tlast;
  logic [STREAM_WIDTH-1:0] w_tdata;
  logic [KEEP_WIDTH-1:0]   w_tkeep;

  // first valid requester at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr} + SUM_W'(k);
      if (w_sum >= SUM_W'(NUM_REQ)) begin
        w_sum = w_sum - SUM_W'(NUM_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && bus.s_axis_tvalid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_tdata = '0;
    w_tkeep = '0;
    w_tlast = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_tdata = bus.s_axis_tdata[i*STREAM_WIDTH +: STREAM_WIDTH];
        w_tkeep = bus.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        w_tlast = bus.s_axis_tlast[i];
      end
    end
  end

  assign w_ok     = r_cnt < CNT_WIDTH'(MAX_IN_FLIGHT);
  assign w_stream = (r_state == STREAM) && !reset;
  assign w_vsel   = |(r_grant & bus.s_axis_tvalid);
  assign w_mvalid = w_stream && w_vsel && w_ok;
  assign w_fwd    = w_mvalid && bus.m_axis_tready;
  assign w_last   = w_fwd && w_tlast;

  assign bus.m_axis_tvalid = w_mvalid;
  assign bus.m_axis_tdata  = w_tdata;
  assign bus.m_axis_tkeep  = w_tkeep;
  assign bus.m_axis_tlast  = w_tlast;
  assign bus.s_axis_tready =
    (w_stream && w_ok && bus.m_axis_tready) ? r_grant : '0;

  assign released = r_released;
  assign grant    = r_grant;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_rr_nxt    = r_rr;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = NUM_REQ'(1) << w_win;
          w_gidx_nxt  = w_win;
          w_state_nxt = bus.s_fence[w_win] ? DRAIN : STREAM;
        end
      end
      DRAIN: begin
        if (r_cnt == '0) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (w_last) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_rr_nxt    = (r_gidx == PTR_W'(NUM_REQ - 1)) ?
                        '0 : r_gidx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // release at zero is dropped; a beat plus a release cancel out
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_fwd && !sigRelease) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (!w_fwd && sigRelease && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr       <= '0;
      r_cnt      <= '0;
      r_released <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_gidx     <= w_gidx_nxt;
      r_rr       <= w_rr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_released <= (w_cnt_nxt == '0);
    end
  end

endmodule

// File: tb/tb_stream_semaphore_arbiter.sv
// Bench for stream_semaphore_arbiter: directed vector table, corner
// sequences, and randomized traffic against a packet-level model.
module tb_stream_semaphore_arbiter;

  localparam int NR  = 3;
  localparam int SW  = 32;
  localparam int KW  = 1;
  localparam int MAX = 4;
  localparam int CW  = 8;

  logic          aclk = 1'b0;
  logic          reset;
  logic          sigRelease;
  logic          released;
  logic [NR-1:0] grant;

  stream_semaphore_arbiter_if #(
    .NUM_REQ(NR), .STREAM_WIDTH(SW), .KEEP_WIDTH(KW)
  ) bus ();

  stream_semaphore_arbiter #(
    .NUM_REQ(NR), .STREAM_WIDTH(SW), .KEEP_WIDTH(KW),
    .MAX_IN_FLIGHT(MAX), .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk),
    .reset(reset),
    .bus(bus),
    .sigRelease(sigRelease),
    .released(released),
    .grant(grant)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [NR-1:0] v;
    logic [NR-1:0] l;
    logic          rdy;
    logic          rel;
    logic [NR-1:0] eg;
    logic          emv;
    logic          eml;
    logic [NR-1:0] esr;
    logic          erl;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drv(logic [NR-1:0] v, logic [NR-1:0] l,
                     logic [NR-1:0] f, logic rdy, logic rel);
    bus.s_axis_tvalid = v;
    bus.s_axis_tlast  = l;
    bus.s_fence       = f;
    bus.m_axis_tready = rdy;
    sigRelease        = rel;
  endtask

  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv('0, '0, '0, 1'b1, 1'b0);
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  // model state
  int m_own;
  bit m_wdr;
  int m_rr;
  int m_cnt;
  bit m_rl;

  task automatic model_reset();
    m_own = -1;
    m_wdr = 1'b0;
    m_rr  = 0;
    m_cnt = 0;
    m_rl  = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] gseq[4];
    int            ng;
    logic [NR-1:0] pg;
    int            bc[NR];
    logic [NR-1:0] lv;
    logic [NR-1:0] hs;

    bus.s_axis_tdata = {32'hC2, 32'hC1, 32'hC0};
    bus.s_axis_tkeep = 3'b101;
    drv('0, '0, '0, 1'b1, 1'b0);
    reset = 1'b0;

    //               v       l       rdy   rel   eg      emv   eml   esr     erl
    tbl[0]  = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1};
    tbl[1]  = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 3'b001, 1'b1};
    tbl[2]  = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 3'b001, 1'b0};
    tbl[3]  = '{3'b001, 3'b001, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 3'b001, 1'b0};
    tbl[4]  = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[5]  = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[6]  = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 3'b001, 1'b0};
    tbl[7]  = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[8]  = '{3'b001, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[9]  = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 3'b001, 1'b0};
    tbl[10] = '{3'b001, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[11] = '{3'b001, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[12] = '{3'b001, 3'b001, 1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001, 1'b0};
    tbl[13] = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0};

    // reset state, 3-beat packet, credit stall, simultaneous fwd+release
    do_reset();
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_released", released, 1);
    chk("rst_tready", bus.s_axis_tready, 0);
    chk("rst_mvalid", bus.m_axis_tvalid, 0);
    nxt();
    for (int r = 0; r < 14; r++) begin
      drv(tbl[r].v, tbl[r].l, '0, tbl[r].rdy, tbl[r].rel);
      #2;
      chk($sformatf("tbl%0d_grant", r), grant, tbl[r].eg);
      chk($sformatf("tbl%0d_mvalid", r), bus.m_axis_tvalid, tbl[r].emv);
      chk($sformatf("tbl%0d_tready", r), bus.s_axis_tready, tbl[r].esr);
      chk($sformatf("tbl%0d_released", r), released, tbl[r].erl);
      if (tbl[r].emv) begin
        chk($sformatf("tbl%0d_mlast", r), bus.m_axis_tlast, tbl[r].eml);
      end
      nxt();
    end

    // alternation between two always-valid requesters, 2-beat packets
    do_reset();
    ng = 0;
    pg = '0;
    for (int i = 0; i < NR; i++) bc[i] = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      for (int i = 0; i < NR; i++) lv[i] = (bc[i] == 1);
      drv(3'b011, lv, '0, 1'b1, 1'b1);
      #2;
      if (grant != '0 && pg == '0) begin
        gseq[ng] = grant;
        ng++;
      end
      pg = grant;
      hs = bus.s_axis_tready & bus.s_axis_tvalid;
      nxt();
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) bc[i] = lv[i] ? 0 : bc[i] + 1;
      end
    end
    chk("rr_count", ng, 4);
    chk("rr_g0", (ng > 0) ? gseq[0] : 3'b000, 3'b001);
    chk("rr_g1", (ng > 1) ? gseq[1] : 3'b000, 3'b010);
    chk("rr_g2", (ng > 2) ? gseq[2] : 3'b000, 3'b001);
    chk("rr_g3", (ng > 3) ? gseq[3] : 3'b000, 3'b010);

    // fence waits for drain
    do_reset();
    drv(3'b001, 3'b000, '0, 1'b1, 1'b0);
    nxt();
    nxt();
    drv(3'b001, 3'b001, '0, 1'b1, 1'b0);
    nxt();
    drv(3'b010, 3'b000, 3'b010, 1'b1, 1'b0);
    nxt();
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("fence_grant", grant, 3'b010);
      chk("fence_mvalid", bus.m_axis_tvalid, 0);
      chk("fence_tready", bus.s_axis_tready, 0);
      chk("fence_released", released, 0);
      nxt();
    end
    drv(3'b010, 3'b000, 3'b010, 1'b1, 1'b1);
    #2;
    chk("fence_rel1_mvalid", bus.m_axis_tvalid, 0);
    nxt();
    #2;
    chk("fence_rel2_mvalid", bus.m_axis_tvalid, 0);
    chk("fence_rel2_released", released, 0);
    nxt();
    drv(3'b010, 3'b000, 3'b010, 1'b1, 1'b0);
    #2;
    chk("fence_zero_released", released, 1);
    chk("fence_zero_mvalid", bus.m_axis_tvalid, 0);
    nxt();
    #2;
    chk("fence_go_mvalid", bus.m_axis_tvalid, 1);
    chk("fence_go_tready", bus.s_axis_tready, 3'b010);
    chk("fence_go_data", bus.m_axis_tdata, 32'hC1);

    // release at zero is ignored
    do_reset();
    drv('0, '0, '0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      nxt();
      #2;
      chk("relzero_released", released, 1);
    end
    nxt();
    drv(3'b100, 3'b100, '0, 1'b1, 1'b0);
    nxt();
    #2;
    chk("relzero_mvalid", bus.m_axis_tvalid, 1);
    chk("relzero_tready", bus.s_axis_tready, 3'b100);
    nxt();
    drv('0, '0, '0, 1'b1, 1'b0);
    #2;
    chk("relzero_cnt1", released, 0);
    drv('0, '0, '0, 1'b1, 1'b1);
    nxt();
    #2;
    chk("relzero_back", released, 1);
    nxt();

    // reset in the middle of a packet
    do_reset();
    drv(3'b001, 3'b001, '0, 1'b1, 1'b0);
    nxt();
    nxt();
    drv(3'b010, 3'b000, '0, 1'b1, 1'b0);
    nxt();
    nxt();
    #2;
    chk("midrst_beat2_mvalid", bus.m_axis_tvalid, 1);
    reset = 1'b1;
    #1;
    chk("midrst_inrst_mvalid", bus.m_axis_tvalid, 0);
    chk("midrst_inrst_tready", bus.s_axis_tready, 0);
    nxt();
    reset = 1'b0;
    drv(3'b111, 3'b000, '0, 1'b1, 1'b0);
    #1;
    chk("midrst_grant", grant, 0);
    chk("midrst_released", released, 1);
    chk("midrst_tready", bus.s_axis_tready, 0);
    nxt();
    #2;
    chk("midrst_rr_grant", grant, 3'b001);
    nxt();

    // randomized traffic against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [NR-1:0] v;
      logic [NR-1:0] l;
      logic [NR-1:0] f;
      logic          rdy;
      logic          rel;
      logic          rst;
      logic [NR-1:0] eg;
      logic [NR-1:0] esr;
      logic          emv;
      logic [NR*SW-1:0] sd;
      logic [NR*KW-1:0] sk;
      bit            ok;
      bit            strm;
      bit            fwd;
      int            cold;

      for (int i = 0; i < NR; i++) begin
        v[i] = ($urandom_range(99) < 70);
        l[i] = ($urandom_range(99) < 30);
        f[i] = ($urandom_range(99) < 15);
      end
      rdy = ($urandom_range(99) < 75);
      rel = ($urandom_range(99) < 35);
      rst = ($urandom_range(199) == 0);
      bus.s_axis_tdata = {$urandom, $urandom, $urandom};
      bus.s_axis_tkeep = NR'($urandom);
      drv(v, l, f, rdy, rel);
      reset = rst;

      eg   = (m_own >= 0) ? NR'(1 << m_own) : '0;
      strm = (m_own >= 0) && !m_wdr && !rst;
      ok   = (m_cnt < MAX);
      emv  = strm && ok && v[m_own];
      esr  = (strm && ok && rdy) ? NR'(1 << m_own) : '0;
      #2;
      chk("rnd_grant", grant, eg);
      chk("rnd_released", released, m_rl);
      chk("rnd_mvalid", bus.m_axis_tvalid, emv);
      chk("rnd_tready", bus.s_axis_tready, esr);
      if (emv) begin
        sd = bus.s_axis_tdata >> (m_own * SW);
        sk = bus.s_axis_tkeep >> (m_own * KW);
        chk("rnd_data", bus.m_axis_tdata, sd[SW-1:0]);
        chk("rnd_keep", bus.m_axis_tkeep, sk[KW-1:0]);
        chk("rnd_last", bus.m_axis_tlast, l[m_own]);
      end
      nxt();

      if (rst) begin
        model_reset();
      end else begin
        fwd  = emv && rdy;
        cold = m_cnt;
        if (fwd && !rel) m_cnt++;
        else if (!fwd && rel && m_cnt > 0) m_cnt--;
        if (m_own < 0) begin
          for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_rr + k) % NR;
            if (m_own < 0 && v[idx]) begin
              m_own = idx;
              m_wdr = f[idx];
            end
          end
        end else if (m_wdr) begin
          if (cold == 0) m_wdr = 1'b0;
        end else if (fwd && l[m_own]) begin
          m_rr  = (m_own + 1) % NR;
          m_own = -1;
        end
        m_rl = (m_cnt == 0);
      end
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
